ov7670_sccb_config: RTL
=======================

Name: ov7670_sccb_config

Overview:
Sequencer and SCCB write master that consumes the OV7670 register table (16-bit {reg_addr, reg_data} ROM indexed by a 6-bit index). On start it walks the table from index 0 and issues one 3-phase SCCB write per entry (device address, register address, register data). It stops at the 16'hFFFF terminator. It drives the camera's SIOC/SIOD pins (SIOD open-drain) and reports busy/done to the top level, which holds off the capture path until done.

Parameters:
CLK_HZ, 24000000, i_clk frequency in Hz.
SCCB_HZ, 100000, SIOC frequency in Hz; Q = CLK_HZ/(4*SCCB_HZ) cycles per quarter bit, must be >= 1.
DEVICE_ADDR, 8'h42, SCCB write address of the camera.
RESET_WAIT_CYCLES, 24000, extra idle cycles after writing 16'h1280 (COM7 soft reset).

Ports:
i_clk  in  1  system clock.
i_rst  in  1  asynchronous active-high reset.
i_start  in  1  single-cycle pulse; begins configuration from index 0.
o_reg_index  out  6  table index presented to the register ROM.
i_addr_data  in  16  ROM output {addr[15:8], data[7:0]}; valid 2 cycles after o_reg_index changes (1-cycle registered ROM).
o_sioc  out  1  SCCB clock, push-pull.
o_siod_oe  out  1  1 = drive SIOD low, 0 = release (pulled high externally).
o_busy  out  1  high from accepted start until done.
o_done  out  1  level; high after terminator, cleared by next accepted start.

Behaviour:
- Reset (async, immediate): o_sioc=1, o_siod_oe=0, o_reg_index=0, o_busy=0, o_done=0, state IDLE, all counters 0. Reset mid-transaction releases the bus at once; no STOP is generated.
- States: IDLE -> FETCH -> CHECK -> START -> BITS -> STOP -> GAP -> (WAIT if entry was 16'h1280) -> FETCH with index+1.
- IDLE: bus idle (sioc=1, oe=0). On i_start, set busy=1, done=0, index=0, and go to FETCH. i_start is ignored while busy.
- FETCH: hold index for 2 cycles, then latch i_addr_data into a 16-bit shadow register.
- CHECK: if shadow==16'hFFFF, go to IDLE with busy=0 and done=1. Otherwise go to START.
- START: sioc=1, oe=1 for 2Q cycles; then sioc=0 and go to BITS.
- BITS: 27 bit slots, MSB first, in this order: DEVICE_ADDR[7:0], don't-care, shadow[15:8], don't-care, shadow[7:0], don't-care.
  - Each slot is 4Q: quarter0 and quarter1 sioc=0; quarter2 and quarter3 sioc=1.
  - oe = ~bit, set at the start of quarter0 and held for the whole slot.
  - Don't-care (9th) slots use oe=0. SIOD is never sampled; no ACK checking.
- STOP: quarter0 sioc=0, oe=1; quarter1 sioc=1, oe=1; quarter2 and quarter3 sioc=1, oe=0.
- GAP: bus idle for 4Q cycles.
- WAIT: entered only when shadow==16'h1280; bus idle for RESET_WAIT_CYCLES.
- Index advance: index increments after GAP/WAIT. If index==63 after a write completes, finish as for the terminator (done=1, index stays 63, no wrap).
- Transaction length: 2Q + 108Q + 4Q = 114Q cycles from START entry to GAP entry.
- o_sioc and o_siod_oe are registered outputs; no combinational path from i_addr_data to the pins.
- i_start in the same cycle as done asserting is ignored. i_start after done restarts from index 0 and clears done.

Test Plan:
1. Reset check (CLK_HZ=800, SCCB_HZ=100 -> Q=2): assert i_rst mid-cycle -> outputs immediately show sioc=1, oe=0, index=0, busy=0, done=0.
2. Single write: ROM model {0:16'h3A04, 1:16'hFFFF}; pulse i_start.
   - Bus decoder sees exactly one START, bytes 0x42, 0x3A, 0x04, one STOP.
   - Each SIOC high phase = 2Q = 4 cycles.
   - Ends with done=1, busy=0, index=1.
3. COM7 wait: ROM model {0:16'h1280, 1:16'h1180, 2:16'hFFFF}, RESET_WAIT_CYCLES=100.
   - Two writes are observed.
   - Gap from first STOP end to second START >= 4Q+100 = 108 cycles.
   - Gap after the second write before done = 4Q only.
4. Full table: 42-entry OV7670 QVGA RGB565 table with FFFF default.
   - Exactly 42 decoded writes, in index order, with matching addr/data.
   - Final index=42, done=1.
   - i_start pulsed mid-run has no effect.
5. Abort and restart: assert i_rst during byte 2 of write 5.
   - Bus released the same cycle.
   - New i_start replays from index 0, first byte 0x42, with the full sequence correct.
6. No terminator: ROM returns 16'h1111 for all indices -> 64 writes (index 0..63), then done=1 with index=63; no wrap to 0.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// OV7670 register-table sequencer: walks a {addr,data} ROM from index 0 and issues
// one 3-phase SCCB write per entry until the 16'hFFFF terminator or index 63.
module ov7670_sccb_config #(
  parameter int          CLK_HZ            = 24000000,
  parameter int          SCCB_HZ           = 100000,
  parameter logic [7:0]  DEVICE_ADDR       = 8'h42,
  parameter int          RESET_WAIT_CYCLES = 24000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [5:0]  o_reg_index,
  input  logic [15:0] i_addr_data,
  output logic        o_sioc,
  output logic        o_siod_oe,
  output logic        o_busy,
  output logic        o_done
);

  localparam int Q    = CLK_HZ / (4 * SCCB_HZ);
  localparam int CMAX = (RESET_WAIT_CYCLES > 4 * Q) ? RESET_WAIT_CYCLES : 4 * Q;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_Q     = CW'(Q - 1);
  localparam logic [CW-1:0] C_2Q    = CW'(2 * Q - 1);
  localparam logic [CW-1:0] C_4Q    = CW'(4 * Q - 1);
  localparam logic [CW-1:0] C_WAIT  = CW'(RESET_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] C_FETCH = CW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CHECK, S_START, S_BITS, S_STOP, S_GAP, S_WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [1:0]    r_qtr, w_qtr;
  logic [4:0]    r_slot, w_slot;
  logic [15:0]   r_shadow, w_shadow;
  logic [5:0]    r_idx, w_idx;
  logic          r_sioc, w_sioc;
  logic          r_oe, w_oe;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          w_adv;
  logic [26:0]   w_frame;

  // 9th slot of each byte is the ACK slot: a 1 here means SIOD released.
  assign w_frame = {DEVICE_ADDR, 1'b1, r_shadow[15:8], 1'b1, r_shadow[7:0], 1'b1};

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt + CW'(1);
    w_qtr    = r_qtr;
    w_slot   = r_slot;
    w_shadow = r_shadow;
    w_idx    = r_idx;
    w_sioc   = r_sioc;
    w_oe     = r_oe;
    w_busy   = r_busy;
    w_done   = r_done;
    w_adv    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt  = '0;
        w_sioc = 1'b1;
        w_oe   = 1'b0;
        if (i_start) begin
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_idx   = '0;
          w_state = S_FETCH;
        end
      end
      S_FETCH: if (r_cnt == C_FETCH) begin
        w_shadow = i_addr_data;
        w_cnt    = '0;
        w_state  = S_CHECK;
      end
      S_CHECK: begin
        w_cnt = '0;
        if (r_shadow == 16'hFFFF) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_state = S_START;
          w_sioc  = 1'b1;
          w_oe    = 1'b1;
        end
      end
      S_START: if (r_cnt == C_2Q) begin
        w_state = S_BITS;
        w_cnt   = '0;
        w_qtr   = '0;
        w_slot  = '0;
        w_sioc  = 1'b0;
        w_oe    = ~w_frame[26];
      end
      S_BITS: if (r_cnt == C_Q) begin
        w_cnt = '0;
        w_qtr = r_qtr + 2'd1;
        if (r_qtr == 2'd1) w_sioc = 1'b1;
        else if (r_qtr == 2'd3) begin
          w_sioc = 1'b0;
          if (r_slot == 5'd26) begin
            w_state = S_STOP;
            w_oe    = 1'b1;
          end else begin
            w_slot = r_slot + 5'd1;
            w_oe   = ~w_frame[5'd25 - r_slot];
          end
        end
      end
      S_STOP: if (r_cnt == C_Q) begin
        w_cnt = '0;
        w_qtr = r_qtr + 2'd1;
        case (r_qtr)
          2'd0:    w_sioc  = 1'b1;
          2'd1:    w_oe    = 1'b0;
          2'd3:    w_state = S_GAP;
          default: ;
        endcase
      end
      S_GAP: if (r_cnt == C_4Q) begin
        w_cnt = '0;
        if (r_shadow == 16'h1280 && RESET_WAIT_CYCLES > 0) w_state = S_WAIT;
        else w_adv = 1'b1;
      end
      S_WAIT: if (r_cnt == C_WAIT) w_adv = 1'b1;
      default: w_state = S_IDLE;
    endcase
    // Index 63 is the last slot the ROM can address, so stop rather than wrap.
    if (w_adv) begin
      w_cnt = '0;
      if (r_idx == 6'd63) begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end else begin
        w_idx   = r_idx + 6'd1;
        w_state = S_FETCH;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_qtr    <= '0;
      r_slot   <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_sioc   <= 1'b1;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_qtr    <= w_qtr;
      r_slot   <= w_slot;
      r_shadow <= w_shadow;
      r_idx    <= w_idx;
      r_sioc   <= w_sioc;
      r_oe     <= w_oe;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign o_reg_index = r_idx;
  assign o_sioc      = r_sioc;
  assign o_siod_oe   = r_oe;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
